// File: rtl/mandel_iter_ctrl_if.sv
// Point input, generator feedback and result signals of the escape-time controller.
interface mandel_iter_ctrl_if #(
  parameter int ITER_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       c_re;
  logic [31:0]       c_im;
  logic [ITER_W-1:0] max_iter;
  logic [31:0]       gen_a;
  logic [31:0]       gen_b;
  logic [31:0]       gen_aa_minus_bb;
  logic [31:0]       gen_two_ab;
  logic [31:0]       gen_aa_plus_bb;
  logic              out_valid;
  logic              out_ready;
  logic [ITER_W-1:0] out_iter;
  logic              out_escaped;
  logic              busy;

  modport slave (
    input  in_valid, c_re, c_im, max_iter,
    input  gen_aa_minus_bb, gen_two_ab, gen_aa_plus_bb,
    input  out_ready,
    output in_ready, gen_a, gen_b, out_valid, out_iter, out_escaped, busy
  );

  modport master (
    output in_valid, c_re, c_im, max_iter,
    output gen_aa_minus_bb, gen_two_ab, gen_aa_plus_bb,
    output out_ready,
    input  in_ready, gen_a, gen_b, out_valid, out_iter, out_escaped, busy
  );
endinterface

// File: rtl/mandel_iter_ctrl.sv
// Escape-time controller: runs z <- z^2 + c through an external squaring
// generator for one point at a time and reports the iteration count.
module mandel_iter_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int ITER_W  = 16,
  parameter int FRAC    = 28
) (
  input  logic               clk,
  input  logic               rst,
  mandel_iter_ctrl_if.slave  bus
);

  localparam int          WAIT_W    = $clog2(MUL_LAT + 1);
  localparam logic [32:0] ESC_LIMIT = 33'(4) << FRAC;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DONE} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       c_re_q, c_im_q;
  logic [31:0]       z_re, z_im;
  logic [ITER_W-1:0] max_iter_q;
  logic [ITER_W-1:0] count;
  logic [ITER_W-1:0] out_iter_q;
  logic              escaped_q;
  logic              accept, escape, at_limit;

  assign accept   = bus.in_valid && (state == IDLE);
  // |z|^2 arrives as an unsigned magnitude; exactly 4.0 must not escape.
  assign escape   = {1'b0, bus.gen_aa_plus_bb} > ESC_LIMIT;
  assign at_limit = (count == max_iter_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == WAIT_W'(1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = (escape || at_limit) ? DONE : ISSUE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_re       <= '0;
      z_im       <= '0;
      count      <= '0;
      out_iter_q <= '0;
      escaped_q  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            z_re  <= '0;
            z_im  <= '0;
            count <= '0;
          end
        end
        ISSUE: wait_cnt <= WAIT_W'(MUL_LAT);
        WAIT:  wait_cnt <= wait_cnt - 1'b1;
        UPDATE: begin
          if (escape || at_limit) begin
            out_iter_q <= count;
            escaped_q  <= escape;
          end else begin
            z_re  <= bus.gen_aa_minus_bb + c_re_q;
            z_im  <= bus.gen_two_ab + c_im_q;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand captures carry no reset; they are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      c_re_q     <= bus.c_re;
      c_im_q     <= bus.c_im;
      max_iter_q <= bus.max_iter;
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.gen_a       = z_re;
  assign bus.gen_b       = z_im;
  assign bus.out_iter    = out_iter_q;
  assign bus.out_escaped = escaped_q;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Self-checking bench for mandel_iter_ctrl: models the squaring generator,
// runs directed vectors, corner sequences and random points against a reference.
module tb_mandel_iter_ctrl;

  localparam int          MUL_LAT = 3;
  localparam int          ITER_W  = 16;
  localparam int          FRAC    = 28;
  localparam int          TIMEOUT = 2000;
  localparam logic [32:0] THRESH  = 33'(4) << FRAC;

  localparam logic [31:0] ONE     = 32'h1000_0000;
  localparam logic [31:0] NEG_ONE = 32'hF000_0000;
  localparam logic [31:0] THREE   = 32'h3000_0000;

  typedef struct packed {
    logic [31:0] amb;
    logic [31:0] tab;
    logic [31:0] apb;
  } gen_t;

  typedef struct {
    logic [31:0] c_re;
    logic [31:0] c_im;
    int          max_iter;
    int          exp_iter;
    bit          exp_esc;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mandel_iter_ctrl_if #(.ITER_W(ITER_W)) bus ();

  mandel_iter_ctrl #(.MUL_LAT(MUL_LAT), .ITER_W(ITER_W), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Fixed-point squaring of z = a + jb, truncated to 32 bits.
  function automatic gen_t gen_math(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, aa, bb, ab;
    gen_t   r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    aa = sa * sa;
    bb = sb * sb;
    ab = sa * sb;
    r.amb = 32'((aa >>> FRAC) - (bb >>> FRAC));
    r.tab = 32'(ab >>> (FRAC - 1));
    r.apb = 32'((aa >>> FRAC) + (bb >>> FRAC));
    return r;
  endfunction

  // Generator model: results reflect a/b as they were MUL_LAT cycles earlier.
  logic [31:0] pa [MUL_LAT] = '{default: 32'h0};
  logic [31:0] pb [MUL_LAT] = '{default: 32'h0};
  gen_t        gen_res;

  always @(posedge clk) begin
    pa[0] <= bus.gen_a;
    pb[0] <= bus.gen_b;
    for (int i = 1; i < MUL_LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end

  always_comb begin
    gen_res             = gen_math(pa[MUL_LAT-1], pb[MUL_LAT-1]);
    bus.gen_aa_minus_bb = gen_res.amb;
    bus.gen_two_ab      = gen_res.tab;
    bus.gen_aa_plus_bb  = gen_res.apb;
  end

  // Reference: plain escape-time loop over the same fixed-point arithmetic.
  function automatic void ref_point(input logic [31:0] cr, input logic [31:0] ci,
                                    input int mi, output int it, output bit esc);
    logic [31:0] zr = '0;
    logic [31:0] zi = '0;
    gen_t        g;
    it  = 0;
    esc = 1'b0;
    for (int n = 0; n <= mi; n++) begin
      it = n;
      g  = gen_math(zr, zi);
      if ({1'b0, g.apb} > THRESH) begin
        esc = 1'b1;
        break;
      end
      zr = g.amb + cr;
      zi = g.tab + ci;
    end
  endfunction

  // Cycle index of the first out_valid, counting the accept cycle as 0.
  function automatic int lat(input int k);
    return 1 + (k + 1) * (MUL_LAT + 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks begin and end at a falling edge.
  task automatic send(input logic [31:0] cr, input logic [31:0] ci, input int mi);
    int guard = 0;
    bus.c_re     = cr;
    bus.c_im     = ci;
    bus.max_iter = ITER_W'(mi);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    check("send.in_ready", bus.in_ready, 1);
  endtask

  // Entered in the accept cycle; scrambles inputs afterwards to prove capture.
  task automatic wait_done(input string name, input int exp_iter, input bit exp_esc);
    int cyc = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.c_re     = $urandom;
    bus.c_im     = $urandom;
    bus.max_iter = ITER_W'($urandom);
    check({name, ".busy"}, bus.busy, 1);
    while (!bus.out_valid && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check({name, ".latency"}, cyc, lat(exp_iter));
    check({name, ".out_iter"}, bus.out_iter, exp_iter);
    check({name, ".out_escaped"}, bus.out_escaped, exp_esc);
  endtask

  task automatic release_result(input string name, input int hold);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, ".idle_ready"}, bus.in_ready, 1);
    check({name, ".idle_valid"}, bus.out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   it;
    bit   esc;
    logic [31:0] cr, ci;
    int   mi;

    vecs[0] = '{ONE,     32'h0, 100, 3,  1'b1, "c_one"};
    vecs[1] = '{NEG_ONE, 32'h0, 16,  16, 1'b0, "c_neg_one"};
    vecs[2] = '{32'h0,   ONE,   16,  16, 1'b0, "c_i"};
    vecs[3] = '{THREE,   32'h0, 0,   0,  1'b0, "c_three_max0"};
    vecs[4] = '{THREE,   32'h0, 5,   1,  1'b1, "c_three_max5"};

    bus.in_valid  = 1'b0;
    bus.c_re      = '0;
    bus.c_im      = '0;
    bus.max_iter  = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.in_ready", bus.in_ready, 1);
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.gen_a", bus.gen_a, 0);
    check("reset.gen_b", bus.gen_b, 0);
    check("reset.busy", bus.busy, 0);
    check("reset.out_iter", bus.out_iter, 0);
    check("reset.out_escaped", bus.out_escaped, 0);

    // Directed table
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].c_re, vecs[v].c_im, vecs[v].max_iter);
      wait_done(vecs[v].name, vecs[v].exp_iter, vecs[v].exp_esc);
      release_result(vecs[v].name, 1);
    end

    // Back-pressure in DONE with a new point waiting
    send(ONE, 32'h0, 100);
    wait_done("bp_first", 3, 1'b1);
    bus.c_re     = THREE;
    bus.c_im     = 32'h0;
    bus.max_iter = ITER_W'(5);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp.out_valid", bus.out_valid, 1);
      check("bp.out_iter", bus.out_iter, 3);
      check("bp.out_escaped", bus.out_escaped, 1);
      check("bp.in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp.release_ready", bus.in_ready, 1);
    check("bp.release_valid", bus.out_valid, 0);
    wait_done("bp_second", 1, 1'b1);
    release_result("bp_second", 0);

    // Reset during WAIT of the second iteration
    send(ONE, 32'h0, 100);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    check("rst_mid.gen_a_z1", bus.gen_a, ONE);
    check("rst_mid.busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.in_ready", bus.in_ready, 1);
    check("rst_mid.busy_clr", bus.busy, 0);
    check("rst_mid.gen_a", bus.gen_a, 0);
    check("rst_mid.gen_b", bus.gen_b, 0);
    check("rst_mid.out_valid", bus.out_valid, 0);
    check("rst_mid.out_iter", bus.out_iter, 0);
    check("rst_mid.out_escaped", bus.out_escaped, 0);
    send(NEG_ONE, 32'h0, 16);
    wait_done("rst_mid_fresh", 16, 1'b0);
    release_result("rst_mid_fresh", 0);

    // Random points in the |c| <= 2 square
    for (int p = 0; p < 25; p++) begin
      cr = 32'($signed($urandom) >>> 2);
      ci = 32'($signed($urandom) >>> 2);
      mi = int'($urandom_range(0, 24));
      ref_point(cr, ci, mi, it, esc);
      send(cr, ci, mi);
      wait_done("rand", it, esc);
      release_result("rand", int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mandel_iter_ctrl.md
Name: mandel_iter_ctrl

Overview:
Sequences the generator datapath (aa_minus_bb, two_ab, aa_plus_bb) to run the escape-time iteration z <- z^2 + c for one point c.
- Accepts c over a valid/ready input and feeds z back into the generator every iteration.
- Detects escape and returns the iteration count over a valid/ready output.
- Sits between the pixel scheduler and the generator; one point in flight at a time.

Parameters:
MUL_LAT, 3, generator latency in cycles from stable a/b to valid results.
ITER_W, 16, width of iteration counter, max_iter and out_iter.
FRAC, 28, fraction bits of the signed 32-bit fixed-point format (default Q4.28: 1.0 = 0x1000_0000, -1.0 = 0xF000_0000). The escape threshold is 4 << FRAC, and FRAC must be <= 29.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  c_re/c_im/max_iter valid
in_ready  out  1  controller can accept a point
c_re  in  32  real part of c, signed fixed-point
c_im  in  32  imaginary part of c, signed fixed-point
max_iter  in  ITER_W  iteration limit, captured on accept
gen_a  out  32  real part of z, to generator a
gen_b  out  32  imaginary part of z, to generator b
gen_aa_minus_bb  in  32  generator result a^2-b^2
gen_two_ab  in  32  generator result 2ab
gen_aa_plus_bb  in  32  generator result a^2+b^2, read as unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_iter  out  ITER_W  number of z updates performed
out_escaped  out  1  1 = escaped, 0 = hit max_iter
busy  out  1  state != IDLE

Behaviour:
Reset and registers
- Reset (any state, mid-iteration included) forces IDLE.
- Reset values: gen_a=gen_b=0, out_valid=0, out_iter=0, out_escaped=0, iteration count=0, busy=0.
- in_ready = (state==IDLE), so it is 1 in the first cycle after reset.
- gen_a/gen_b are registers holding z. They change only on accept (cleared to 0) and in UPDATE.
- c_re, c_im and max_iter are captured on accept; later changes on the inputs are ignored.

States
- IDLE: in_valid && in_ready -> capture c and max_iter, set z=0, count=0, go ISSUE.
- ISSUE: 1 cycle; z is presented on gen_a/gen_b; load wait counter with MUL_LAT; go WAIT.
- WAIT: exactly MUL_LAT cycles with gen_a/gen_b held stable; then go UPDATE.
- UPDATE: sample generator outputs, then:
  - gen_aa_plus_bb (unsigned) > (4 << FRAC) -> out_escaped=1, out_iter=count, go DONE.
  - else if count == max_iter -> out_escaped=0, out_iter=count, go DONE.
  - else z_re <= gen_aa_minus_bb + c_re, z_im <= gen_two_ab + c_im (32-bit two's-complement wrap), count <= count+1, go ISSUE.
- DONE: out_valid=1, holding out_iter/out_escaped stable. On out_valid && out_ready go IDLE, clearing out_valid in the same edge. A new point is accepted no earlier than the next cycle.

Timing and boundary rules
- Each iteration takes exactly MUL_LAT+2 cycles. A point finishing after k updates reaches DONE 1 + (k+1)(MUL_LAT+2) cycles after the accept edge.
- |z|^2 exactly equal to 4 does not escape (strict >).
- max_iter=0: the first check at z=0 ends with out_iter=0, out_escaped=0.
- The escape test is evaluated before the max_iter test, so escape wins when both hold.
- The count never exceeds max_iter, so it cannot wrap.
- Back-pressure in DONE is unbounded; in_ready stays 0 for the whole time.
- in_valid while busy has no effect and nothing is dropped; the producer holds it.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, gen_a=gen_b=0, busy=0.
- c=(0x1000_0000, 0), max_iter=100 -> z = 1, 2, 5; |z|^2=4 at z=2 does not escape; out_iter=3, out_escaped=1, out_valid exactly 1+4*(MUL_LAT+2) cycles after accept.
- c=(0xF000_0000, 0) (-1.0), max_iter=16 -> z cycles -1,0; out_iter=16, out_escaped=0. Also c=(0, 0x1000_0000) (i), max_iter=16 -> out_iter=16, out_escaped=0.
- c=(0x3000_0000, 0), max_iter=0 -> out_iter=0, out_escaped=0. Same c with max_iter=5 -> out_iter=1, out_escaped=1 (gen_aa_plus_bb=0x9000_0000 read unsigned).
- Hold out_ready=0 for 20 cycles in DONE while driving in_valid with new c -> out_valid, out_iter and out_escaped stay stable, in_ready=0. Release -> IDLE next cycle, then the new point is accepted.
- Assert rst during WAIT of the 2nd iteration -> next cycle IDLE, all outputs at reset values. A fresh point then completes correctly.
